// File: rtl/key_led_pkg.sv
// Shared constants and helpers for the key/LED controller.
package key_led_pkg;

  localparam logic [1:0] MODE_BLINK     = 2'd0;
  localparam logic [1:0] MODE_WALK_UP   = 2'd1;
  localparam logic [1:0] MODE_WALK_DOWN = 2'd2;
  localparam logic [1:0] MODE_BOUNCE    = 2'd3;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchroniser, polarity fix-up, debounce counter and press pulse.
module key_debounce
  import key_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8192,
  parameter bit KEY_ACTIVE_HIGH = 1'b1
) (
  input  logic clk_50m,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic key_press
);

  localparam int DW = clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          lvl_in;
  logic [DW-1:0] db_cnt;

  assign lvl_in = KEY_ACTIVE_HIGH ? sync[1] : ~sync[1];

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      sync      <= '0;
      db_cnt    <= '0;
      key_level <= 1'b0;
      key_press <= 1'b0;
    end else begin
      sync      <= {sync[0], key_raw};
      key_press <= 1'b0;
      if (lvl_in == key_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        // Registered alongside key_level so the pulse lands in the rising cycle.
        key_level <= lvl_in;
        key_press <= lvl_in;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/key_led_ctrl.sv
// Debounced keys step a 2-bit mode selecting one of four LED patterns, advanced by a prescaler.
module key_led_ctrl
  import key_led_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int NUM_LEDS        = 4,
  parameter int DEBOUNCE_CYCLES = 8192,
  parameter int STEP_CYCLES     = 67108864,
  parameter bit KEY_ACTIVE_HIGH = 1'b1
) (
  input  logic                clk_50m,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  input  logic                led_en,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [1:0]          mode,
  output logic                step_tick,
  output logic [NUM_LEDS-1:0] led
);

  localparam int SW = clog2(STEP_CYCLES);
  localparam logic [SW-1:0]       STEP_MAX = SW'(STEP_CYCLES - 1);
  localparam logic [NUM_LEDS-1:0] LED_LSB  = {{(NUM_LEDS-1){1'b0}}, 1'b1};
  localparam logic [NUM_LEDS-1:0] LED_MSB  = {1'b1, {(NUM_LEDS-1){1'b0}}};

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .KEY_ACTIVE_HIGH(KEY_ACTIVE_HIGH)
    ) u_db (
      .clk_50m  (clk_50m),
      .rst      (rst),
      .key_raw  (key[g]),
      .key_level(key_level[g]),
      .key_press(key_press[g])
    );
  end

  logic [1:0]          mode_nxt;
  logic                mode_chg;
  logic [SW-1:0]       step_cnt;
  logic [NUM_LEDS-1:0] pat, pat_nxt;
  logic                dir_dn, dir_dn_nxt;

  // Simultaneous next/prev presses cancel out.
  always_comb begin
    mode_nxt = mode;
    mode_chg = 1'b0;
    if (key_press[0] && !key_press[1]) begin
      mode_nxt = mode + 2'd1;
      mode_chg = 1'b1;
    end else if (key_press[1] && !key_press[0]) begin
      mode_nxt = mode - 2'd1;
      mode_chg = 1'b1;
    end
  end

  assign step_tick = (step_cnt == STEP_MAX);

  always_comb begin
    pat_nxt    = pat;
    dir_dn_nxt = dir_dn;
    if (mode_chg) begin
      dir_dn_nxt = 1'b0;
      case (mode_nxt)
        MODE_BLINK:     pat_nxt = '0;
        MODE_WALK_UP:   pat_nxt = LED_LSB;
        MODE_WALK_DOWN: pat_nxt = LED_MSB;
        MODE_BOUNCE:    pat_nxt = LED_LSB;
        default:        pat_nxt = '0;
      endcase
    end else if (step_tick) begin
      case (mode)
        MODE_BLINK:     pat_nxt = ~pat;
        MODE_WALK_UP:   pat_nxt = {pat[NUM_LEDS-2:0], pat[NUM_LEDS-1]};
        MODE_WALK_DOWN: pat_nxt = {pat[0], pat[NUM_LEDS-1:1]};
        MODE_BOUNCE: begin
          // Turn around on the end bit itself so each end is lit for one step.
          if (!dir_dn) begin
            if (pat[NUM_LEDS-1]) begin
              pat_nxt    = pat >> 1;
              dir_dn_nxt = 1'b1;
            end else begin
              pat_nxt = pat << 1;
            end
          end else begin
            if (pat[0]) begin
              pat_nxt    = pat << 1;
              dir_dn_nxt = 1'b0;
            end else begin
              pat_nxt = pat >> 1;
            end
          end
        end
        default: pat_nxt = pat;
      endcase
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      mode     <= MODE_BLINK;
      step_cnt <= '0;
      pat      <= '0;
      dir_dn   <= 1'b0;
      led      <= '0;
    end else begin
      mode     <= mode_nxt;
      step_cnt <= (mode_chg || step_tick) ? '0 : step_cnt + SW'(1);
      pat      <= pat_nxt;
      dir_dn   <= dir_dn_nxt;
      led      <= pat & {NUM_LEDS{led_en}};
    end
  end

endmodule

// File: tb/tb_key_led_ctrl.sv
// Directed bench for key_led_ctrl with short debounce/step periods.
module tb_key_led_ctrl;

  logic       clk_50m = 1'b0;
  logic       rst;
  logic [2:0] key;
  logic       led_en;
  logic [2:0] key_level;
  logic [2:0] key_press;
  logic [1:0] mode;
  logic       step_tick;
  logic [3:0] led;

  int checks = 0;
  int errors = 0;

  always #10 clk_50m = ~clk_50m;

  key_led_ctrl #(
    .NUM_KEYS(3), .NUM_LEDS(4), .DEBOUNCE_CYCLES(4), .STEP_CYCLES(3), .KEY_ACTIVE_HIGH(1'b1)
  ) dut (
    .clk_50m  (clk_50m),
    .rst      (rst),
    .key      (key),
    .led_en   (led_en),
    .key_level(key_level),
    .key_press(key_press),
    .mode     (mode),
    .step_tick(step_tick),
    .led      (led)
  );

  task automatic cyc();
    @(posedge clk_50m);
    #1;
  endtask

  // Hold a key long enough to debounce, then release and let it settle.
  task automatic press_key(input logic [2:0] mask);
    key = mask;
    repeat (7) cyc();
    key = 3'b000;
    repeat (8) cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1; key = 3'b000; led_en = 1'b1;
    repeat (3) cyc();
    checks++; if (key_level !== 3'b000) begin errors++; $display("FAIL reset_level: got %b expected 000", key_level); end
    checks++; if (key_press !== 3'b000) begin errors++; $display("FAIL reset_press: got %b expected 000", key_press); end
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", mode); end
    checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", step_tick); end
    checks++; if (led !== 4'b0000) begin errors++; $display("FAIL reset_led: got %b expected 0000", led); end
  endtask

  task automatic test_blink();
    logic       exp_tick [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] exp_led  [7] = '{4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0};
    rst = 1'b0;
    for (int c = 0; c < 7; c++) begin
      cyc();
      checks++; if (step_tick !== exp_tick[c]) begin errors++; $display("FAIL blink_tick[%0d]: got %b expected %b", c, step_tick, exp_tick[c]); end
      checks++; if (led !== exp_led[c]) begin errors++; $display("FAIL blink_led[%0d]: got %b expected %b", c, led, exp_led[c]); end
    end
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL blink_mode: got %0d expected 0", mode); end
  endtask

  task automatic test_walk_up();
    logic [3:0] exp_led [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    key = 3'b001;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (c == 10) key = 3'b000;
      if (c <= 5) begin
        checks++; if (key_level[0] !== 1'b0) begin errors++; $display("FAIL walk_level_early[%0d]: got %b expected 0", c, key_level[0]); end
      end
      if (c == 6) begin
        checks++; if (key_level[0] !== 1'b1) begin errors++; $display("FAIL walk_level_rise: got %b expected 1", key_level[0]); end
        checks++; if (key_press !== 3'b001) begin errors++; $display("FAIL walk_press: got %b expected 001", key_press); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL walk_mode_early: got %0d expected 0", mode); end
      end
      if (c >= 7) begin
        checks++; if (key_press !== 3'b000) begin errors++; $display("FAIL walk_press_once[%0d]: got %b expected 000", c, key_press); end
        checks++; if (mode !== 2'd1) begin errors++; $display("FAIL walk_mode[%0d]: got %0d expected 1", c, mode); end
      end
      if (c >= 8 && (c - 8) % 3 == 0) begin
        checks++; if (led !== exp_led[(c-8)/3]) begin errors++; $display("FAIL walk_led[%0d]: got %b expected %b", c, led, exp_led[(c-8)/3]); end
      end
    end
    checks++; if (key_level[0] !== 1'b0) begin errors++; $display("FAIL walk_release_level: got %b expected 0", key_level[0]); end
  endtask

  task automatic test_glitch();
    key = 3'b001;
    for (int c = 1; c <= 11; c++) begin
      cyc();
      if (c == 3) key = 3'b000;
      checks++; if (key_level[0] !== 1'b0) begin errors++; $display("FAIL glitch_level[%0d]: got %b expected 0", c, key_level[0]); end
      checks++; if (key_press !== 3'b000) begin errors++; $display("FAIL glitch_press[%0d]: got %b expected 000", c, key_press); end
      checks++; if (mode !== 2'd1) begin errors++; $display("FAIL glitch_mode[%0d]: got %0d expected 1", c, mode); end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp_led [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    press_key(3'b010);
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL prev_mode: got %0d expected 0", mode); end
    key = 3'b010;
    for (int c = 1; c <= 26; c++) begin
      cyc();
      if (c == 10) key = 3'b000;
      if (c == 6) begin
        checks++; if (key_press !== 3'b010) begin errors++; $display("FAIL bounce_press: got %b expected 010", key_press); end
      end
      if (c >= 7) begin
        checks++; if (mode !== 2'd3) begin errors++; $display("FAIL bounce_mode[%0d]: got %0d expected 3", c, mode); end
      end
      if (c >= 8 && (c - 8) % 3 == 0) begin
        checks++; if (led !== exp_led[(c-8)/3]) begin errors++; $display("FAIL bounce_led[%0d]: got %b expected %b", c, led, exp_led[(c-8)/3]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] masks [2] = '{3'b011, 3'b100};
    for (int m = 0; m < 2; m++) begin
      key = masks[m];
      for (int c = 1; c <= 18; c++) begin
        cyc();
        if (c == 10) key = 3'b000;
        if (c == 6) begin
          checks++; if (key_press !== masks[m]) begin errors++; $display("FAIL b2b_press[%0d]: got %b expected %b", m, key_press, masks[m]); end
          checks++; if (key_level !== masks[m]) begin errors++; $display("FAIL b2b_level[%0d]: got %b expected %b", m, key_level, masks[m]); end
        end
        if (c == 7) begin
          checks++; if (key_press !== 3'b000) begin errors++; $display("FAIL b2b_press_end[%0d]: got %b expected 000", m, key_press); end
        end
        if (c >= 7) begin
          checks++; if (mode !== 2'd3) begin errors++; $display("FAIL b2b_mode[%0d/%0d]: got %0d expected 3", m, c, mode); end
        end
      end
    end
  endtask

  task automatic test_led_en();
    key = 3'b001;
    for (int c = 1; c <= 26; c++) begin
      cyc();
      if (c == 7) begin
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL en_mode_wrap: got %0d expected 0", mode); end
        led_en = 1'b0;
      end
      if (c == 8) key = 3'b000;
      if (c >= 8 && c <= 22) begin
        checks++; if (led !== 4'b0000) begin errors++; $display("FAIL en_off[%0d]: got %b expected 0000", c, led); end
      end
      if (c == 22) led_en = 1'b1;
      if (c == 23) begin
        checks++; if (led !== 4'b1111) begin errors++; $display("FAIL en_resume: got %b expected 1111", led); end
      end
      if (c == 26) begin
        checks++; if (led !== 4'b0000) begin errors++; $display("FAIL en_next_step: got %b expected 0000", led); end
      end
    end
  endtask

  task automatic test_reset_mid();
    press_key(3'b001);
    checks++; if (mode !== 2'd1) begin errors++; $display("FAIL pre_rst_mode: got %0d expected 1", mode); end
    key = 3'b001;
    repeat (4) cyc();
    rst = 1'b1;
    key = 3'b000;
    cyc();
    checks++; if (key_level !== 3'b000) begin errors++; $display("FAIL rst_mid_level: got %b expected 000", key_level); end
    checks++; if (key_press !== 3'b000) begin errors++; $display("FAIL rst_mid_press: got %b expected 000", key_press); end
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL rst_mid_mode: got %0d expected 0", mode); end
    checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL rst_mid_tick: got %b expected 0", step_tick); end
    checks++; if (led !== 4'b0000) begin errors++; $display("FAIL rst_mid_led: got %b expected 0000", led); end
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      checks++; if (key_press !== 3'b000 || key_level !== 3'b000) begin errors++; $display("FAIL rst_after[%0d]: got press %b level %b expected 000/000", c, key_press, key_level); end
      checks++; if (mode !== 2'd0) begin errors++; $display("FAIL rst_after_mode[%0d]: got %0d expected 0", c, mode); end
    end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_walk_up();
    test_glitch();
    test_bounce();
    test_back_to_back();
    test_led_en();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
